// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: instruction encodings, opcodes and datapath width
// used by the IF/ID stage and the downstream decode/execute stages.
package pipeline_pkg;

  typedef logic [6:0] opcode_t;
  typedef logic [4:0] reg_addr_t;

  localparam int          XLEN_DEFAULT = 32;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam opcode_t     HALT_OPCODE  = 7'h7F;

  localparam opcode_t OP_LUI    = 7'h37;
  localparam opcode_t OP_AUIPC  = 7'h17;
  localparam opcode_t OP_JAL    = 7'h6F;
  localparam opcode_t OP_JALR   = 7'h67;
  localparam opcode_t OP_RTYPE  = 7'h33;
  localparam opcode_t OP_ITYPE  = 7'h13;
  localparam opcode_t OP_LOAD   = 7'h03;
  localparam opcode_t OP_STORE  = 7'h23;
  localparam opcode_t OP_BRANCH = 7'h63;

endpackage

// File: rtl/load_use_detector.sv
// Load-use hazard check: decodes which source registers an instruction reads
// and compares them against the destination of a load sitting in ID/EX.
module load_use_detector
  import pipeline_pkg::*;
(
  input  logic       instr_valid,
  input  logic [6:0] opcode,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  output logic       hazard
);

  opcode_t op;
  logic    uses_rs1;
  logic    uses_rs2;
  logic    rs1_hit;
  logic    rs2_hit;

  assign op = opcode;

  // x0 is never a real dependency, so a load targeting it cannot stall.
  always_comb begin
    uses_rs1 = !(op inside {OP_LUI, OP_AUIPC, OP_JAL});
    uses_rs2 = op inside {OP_RTYPE, OP_STORE, OP_BRANCH};
    rs1_hit  = uses_rs1 && (rs1 == ex_rd);
    rs2_hit  = uses_rs2 && (rs2 == ex_rd);
    hazard   = instr_valid && ex_mem_read && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register: captures fetch results, squashes wrong-path fetches
// after a jump, holds on load-use hazards and freezes on HALT.
module if_id_stage #(
  parameter int              XLEN         = pipeline_pkg::XLEN_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR    = XLEN'(pipeline_pkg::NOP_INSTR),
  parameter logic [6:0]      HALT_OPCODE  = pipeline_pkg::HALT_OPCODE,
  parameter int              FLUSH_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] if_instr,
  input  logic [XLEN-1:0] if_pc,
  input  logic [XLEN-1:0] if_next_pc,
  input  logic            jump_taken,
  input  logic            ex_mem_read,
  input  logic [4:0]      ex_rd,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_next_pc,
  output logic            id_valid,
  output logic [6:0]      id_opcode,
  output logic [4:0]      id_rd,
  output logic [4:0]      id_rs1,
  output logic [4:0]      id_rs2,
  output logic            hazard_stall,
  output logic            halt
);

  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] next_pc_q, next_pc_d;
  logic            valid_q, valid_d;
  logic            halt_q, halt_d;
  logic [1:0]      squash_q, squash_d;

  logic            load_use;
  logic            flush;
  logic            halt_hit;

  load_use_detector u_load_use (
    .instr_valid (valid_q),
    .opcode      (instr_q[6:0]),
    .rs1         (instr_q[19:15]),
    .rs2         (instr_q[24:20]),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .hazard      (load_use)
  );

  assign flush        = jump_taken || (squash_q != 2'd0);
  assign halt_hit     = valid_q && (instr_q[6:0] == HALT_OPCODE);
  assign hazard_stall = load_use && !jump_taken && !halt_q;

  // The detecting edge already holds id_*, so the HALT stays visible in decode.
  always_comb begin
    instr_d   = instr_q;
    pc_d      = pc_q;
    next_pc_d = next_pc_q;
    valid_d   = valid_q;
    halt_d    = halt_q;
    squash_d  = squash_q;
    if (halt_q) begin
      halt_d = 1'b1;
    end else if (flush) begin
      instr_d   = NOP_INSTR;
      valid_d   = 1'b0;
      pc_d      = if_pc;
      next_pc_d = if_next_pc;
      squash_d  = jump_taken ? 2'(FLUSH_CYCLES - 1) : squash_q - 2'd1;
    end else if (halt_hit) begin
      halt_d = 1'b1;
    end else if (!hazard_stall) begin
      instr_d   = if_instr;
      pc_d      = if_pc;
      next_pc_d = if_next_pc;
      valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_q   <= NOP_INSTR;
      pc_q      <= '0;
      next_pc_q <= '0;
      valid_q   <= 1'b0;
      halt_q    <= 1'b0;
      squash_q  <= 2'd0;
    end else begin
      instr_q   <= instr_d;
      pc_q      <= pc_d;
      next_pc_q <= next_pc_d;
      valid_q   <= valid_d;
      halt_q    <= halt_d;
      squash_q  <= squash_d;
    end
  end

  assign id_instr   = instr_q;
  assign id_pc      = pc_q;
  assign id_next_pc = next_pc_q;
  assign id_valid   = valid_q;
  assign id_opcode  = instr_q[6:0];
  assign id_rd      = instr_q[11:7];
  assign id_rs1     = instr_q[19:15];
  assign id_rs2     = instr_q[24:20];
  assign halt       = halt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: two instances (one- and two-cycle squash)
// checked every cycle against a behavioural model plus directed literal checks.
module tb_if_id_stage;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] ADDI = 32'h0060_0513;
  localparam logic [31:0] JAL  = 32'h0140_00ef;
  localparam logic [31:0] TGT  = 32'hff81_0113;
  localparam logic [31:0] MUL  = 32'h0255_0533;
  localparam logic [31:0] HLT  = 32'h0000_007F;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_next_pc;
  logic        jump_taken;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;

  logic [31:0] d1_instr, d1_pc, d1_npc;
  logic        d1_valid, d1_stall, d1_halt;
  logic [6:0]  d1_opcode;
  logic [4:0]  d1_rd, d1_rs1, d1_rs2;
  logic [31:0] d2_instr, d2_pc, d2_npc;
  logic        d2_valid, d2_stall, d2_halt;
  logic [6:0]  d2_opcode;
  logic [4:0]  d2_rd, d2_rs1, d2_rs2;

  int errors = 0;
  int checks = 0;
  logic checkEn = 1'b0;

  always #5 clk = ~clk;

  if_id_stage #(.FLUSH_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .if_instr(if_instr), .if_pc(if_pc),
    .if_next_pc(if_next_pc), .jump_taken(jump_taken), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .id_instr(d1_instr), .id_pc(d1_pc), .id_next_pc(d1_npc),
    .id_valid(d1_valid), .id_opcode(d1_opcode), .id_rd(d1_rd), .id_rs1(d1_rs1),
    .id_rs2(d1_rs2), .hazard_stall(d1_stall), .halt(d1_halt)
  );

  if_id_stage #(.FLUSH_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .if_instr(if_instr), .if_pc(if_pc),
    .if_next_pc(if_next_pc), .jump_taken(jump_taken), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .id_instr(d2_instr), .id_pc(d2_pc), .id_next_pc(d2_npc),
    .id_valid(d2_valid), .id_opcode(d2_opcode), .id_rd(d2_rd), .id_rs1(d2_rs1),
    .id_rs2(d2_rs2), .hazard_stall(d2_stall), .halt(d2_halt)
  );

  // Architectural view of the stage: what decode should see, plus squash budget.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        valid;
    logic        halt;
    logic [1:0]  squash;
  } mstate_t;

  mstate_t m1, m2;

  function automatic logic mHazard(mstate_t s);
    logic [6:0] op;
    logic [4:0] r1, r2;
    logic readsRs1, readsRs2;
    op = s.instr[6:0];
    r1 = s.instr[19:15];
    r2 = s.instr[24:20];
    readsRs1 = (op != 7'h37) && (op != 7'h17) && (op != 7'h6F);
    readsRs2 = (op == 7'h33) || (op == 7'h23) || (op == 7'h63);
    return s.valid && ex_mem_read && (ex_rd != 5'd0) && !jump_taken && !s.halt &&
           ((readsRs1 && r1 == ex_rd) || (readsRs2 && r2 == ex_rd));
  endfunction

  function automatic mstate_t mStep(mstate_t s, int flushCycles);
    mstate_t n;
    n = s;
    if (!rst_n) begin
      n.instr = NOP; n.pc = 32'd0; n.npc = 32'd0;
      n.valid = 1'b0; n.halt = 1'b0; n.squash = 2'd0;
    end else if (s.halt) begin
      n = s;
    end else if (jump_taken || s.squash != 2'd0) begin
      n.instr = NOP; n.valid = 1'b0; n.pc = if_pc; n.npc = if_next_pc;
      n.squash = jump_taken ? 2'(flushCycles - 1) : s.squash - 2'd1;
    end else if (s.valid && s.instr[6:0] == 7'h7F) begin
      n.halt = 1'b1;
    end else if (!mHazard(s)) begin
      n.instr = if_instr; n.pc = if_pc; n.npc = if_next_pc; n.valid = 1'b1;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m1 <= mStep(m1, 1);
    m2 <= mStep(m2, 2);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one fetch cycle, then return just after the capturing edge.
  task automatic applyStimulus(input logic rst, input logic [31:0] instr, input logic [31:0] pc,
                               input logic jt, input logic mr, input logic [4:0] rd);
    rst_n       = rst;
    if_instr    = instr;
    if_pc       = pc;
    if_next_pc  = pc + 32'd1;
    jump_taken  = jt;
    ex_mem_read = mr;
    ex_rd       = rd;
    @(posedge clk);
    #1;
  endtask

  // Mid-cycle comparison of every output of both instances against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("d1_instr", d1_instr, m1.instr);
      checkOutput("d1_pc", d1_pc, m1.pc);
      checkOutput("d1_npc", d1_npc, m1.npc);
      checkOutput("d1_valid", 32'(d1_valid), 32'(m1.valid));
      checkOutput("d1_halt", 32'(d1_halt), 32'(m1.halt));
      checkOutput("d1_opcode", 32'(d1_opcode), 32'(m1.instr[6:0]));
      checkOutput("d1_rd", 32'(d1_rd), 32'(m1.instr[11:7]));
      checkOutput("d1_rs1", 32'(d1_rs1), 32'(m1.instr[19:15]));
      checkOutput("d1_rs2", 32'(d1_rs2), 32'(m1.instr[24:20]));
      checkOutput("d1_stall", 32'(d1_stall), 32'(mHazard(m1)));
      checkOutput("d2_instr", d2_instr, m2.instr);
      checkOutput("d2_pc", d2_pc, m2.pc);
      checkOutput("d2_npc", d2_npc, m2.npc);
      checkOutput("d2_valid", 32'(d2_valid), 32'(m2.valid));
      checkOutput("d2_halt", 32'(d2_halt), 32'(m2.halt));
      checkOutput("d2_stall", 32'(d2_stall), 32'(mHazard(m2)));
    end
  end

  initial begin
    applyStimulus(1'b0, ADDI, 32'd0, 1'b0, 1'b0, 5'd0);
    applyStimulus(1'b0, ADDI, 32'd0, 1'b0, 1'b0, 5'd0);
    checkEn = 1'b1;
    checkOutput("rst_instr", d1_instr, NOP);
    checkOutput("rst_valid", 32'(d1_valid), 32'd0);
    checkOutput("rst_pc", d1_pc, 32'd0);
    checkOutput("rst_halt", 32'(d1_halt), 32'd0);

    applyStimulus(1'b1, ADDI, 32'd0, 1'b0, 1'b0, 5'd0);
    checkOutput("cap_instr", d1_instr, ADDI);
    checkOutput("cap_pc", d1_pc, 32'd0);
    checkOutput("cap_npc", d1_npc, 32'd1);
    checkOutput("cap_rd", 32'(d1_rd), 32'd10);
    checkOutput("cap_valid", 32'(d1_valid), 32'd1);

    applyStimulus(1'b1, JAL, 32'd1, 1'b0, 1'b1, 5'd0);
    checkOutput("jal_x0_stall", 32'(d1_stall), 32'd0);
    applyStimulus(1'b1, JAL, 32'd1, 1'b0, 1'b1, 5'd1);
    checkOutput("jal_ra_stall", 32'(d1_stall), 32'd0);
    applyStimulus(1'b1, JAL, 32'd1, 1'b0, 1'b1, 5'd20);
    checkOutput("jal_rs2_stall", 32'(d1_stall), 32'd0);
    checkOutput("jal_instr", d1_instr, JAL);

    applyStimulus(1'b1, NOP, 32'd2, 1'b1, 1'b0, 5'd0);
    checkOutput("flush_instr", d1_instr, NOP);
    checkOutput("flush_valid", 32'(d1_valid), 32'd0);
    checkOutput("flush_pc", d1_pc, 32'd2);
    applyStimulus(1'b1, TGT, 32'd6, 1'b0, 1'b0, 5'd0);
    checkOutput("tgt_instr", d1_instr, TGT);
    checkOutput("tgt_valid", 32'(d1_valid), 32'd1);
    checkOutput("tgt_npc", d1_npc, 32'd7);
    checkOutput("f2_second_squash", 32'(d2_valid), 32'd0);
    applyStimulus(1'b1, ADDI, 32'd7, 1'b0, 1'b0, 5'd0);
    checkOutput("f2_resume_valid", 32'(d2_valid), 32'd1);
    checkOutput("f2_resume_pc", d2_pc, 32'd7);

    applyStimulus(1'b1, ADDI, 32'd20, 1'b1, 1'b0, 5'd0);
    applyStimulus(1'b1, ADDI, 32'd21, 1'b1, 1'b0, 5'd0);
    applyStimulus(1'b1, ADDI, 32'd22, 1'b0, 1'b0, 5'd0);
    checkOutput("rejump_f1_valid", 32'(d1_valid), 32'd1);
    checkOutput("rejump_f2_valid", 32'(d2_valid), 32'd0);
    applyStimulus(1'b1, ADDI, 32'd23, 1'b0, 1'b0, 5'd0);
    checkOutput("rejump_f2_pc", d2_pc, 32'd23);
    checkOutput("rejump_f2_back", 32'(d2_valid), 32'd1);

    applyStimulus(1'b1, MUL, 32'd10, 1'b0, 1'b0, 5'd0);
    checkOutput("mul_rs1", 32'(d1_rs1), 32'd10);
    checkOutput("mul_rs2", 32'(d1_rs2), 32'd5);
    applyStimulus(1'b1, NOP, 32'd11, 1'b0, 1'b1, 5'd5);
    checkOutput("lu_stall", 32'(d1_stall), 32'd1);
    checkOutput("lu_hold_instr", d1_instr, MUL);
    checkOutput("lu_hold_pc", d1_pc, 32'd10);
    applyStimulus(1'b1, NOP, 32'd11, 1'b0, 1'b0, 5'd5);
    checkOutput("lu_release_pc", d1_pc, 32'd11);
    checkOutput("lu_release_stall", 32'(d1_stall), 32'd0);

    applyStimulus(1'b1, MUL, 32'd12, 1'b0, 1'b0, 5'd0);
    applyStimulus(1'b1, NOP, 32'd13, 1'b1, 1'b1, 5'd5);
    checkOutput("flush_beats_stall", 32'(d1_valid), 32'd0);
    checkOutput("flush_beats_pc", d1_pc, 32'd13);
    applyStimulus(1'b1, ADDI, 32'd14, 1'b0, 1'b0, 5'd0);
    applyStimulus(1'b1, ADDI, 32'd15, 1'b0, 1'b0, 5'd0);

    applyStimulus(1'b1, HLT, 32'd30, 1'b0, 1'b0, 5'd0);
    checkOutput("hlt_latched", 32'(d1_halt), 32'd0);
    applyStimulus(1'b1, NOP, 32'd31, 1'b0, 1'b0, 5'd0);
    checkOutput("hlt_set", 32'(d1_halt), 32'd1);
    checkOutput("hlt_freeze_instr", d1_instr, HLT);
    applyStimulus(1'b1, TGT, 32'd32, 1'b1, 1'b1, 5'd3);
    checkOutput("hlt_sticky", 32'(d1_halt), 32'd1);
    checkOutput("hlt_freeze_pc", d1_pc, 32'd30);
    checkOutput("hlt_no_stall", 32'(d1_stall), 32'd0);
    applyStimulus(1'b0, NOP, 32'd0, 1'b0, 1'b0, 5'd0);
    checkOutput("hlt_reset", 32'(d1_halt), 32'd0);

    applyStimulus(1'b1, HLT, 32'd40, 1'b0, 1'b0, 5'd0);
    applyStimulus(1'b1, NOP, 32'd41, 1'b1, 1'b0, 5'd0);
    checkOutput("squashed_hlt", 32'(d1_halt), 32'd0);
    applyStimulus(1'b1, ADDI, 32'd42, 1'b0, 1'b0, 5'd0);
    checkOutput("squashed_hlt_after", 32'(d1_halt), 32'd0);
    checkOutput("squashed_hlt_pc", d1_pc, 32'd42);

    applyStimulus(1'b1, ADDI, 32'd49, 1'b1, 1'b0, 5'd0);
    applyStimulus(1'b0, ADDI, 32'd0, 1'b0, 1'b0, 5'd0);
    applyStimulus(1'b1, ADDI, 32'd50, 1'b0, 1'b0, 5'd0);
    checkOutput("rst_midflush_valid", 32'(d2_valid), 32'd1);
    checkOutput("rst_midflush_pc", d2_pc, 32'd50);

    @(negedge clk);
    checkEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
